// File: rtl/au_down_counter_if.sv
// Load/status bundle for au_down_counter. The master drives the load request and
// run controls; the slave (the counter) returns ld_ready, the count and the status flags.
interface au_down_counter_if #(
  parameter int WIDTH = 8
);
  // Load handshake: a load transfers on a rising clk edge where ld_valid and ld_ready
  // are both high. ld_data only has to be stable while ld_valid is high. ld_ready is
  // combinational: it is high outside RUN and is forced low by abort.
  logic             ld_valid;
  logic             ld_ready;
  logic [WIDTH-1:0] ld_data;
  logic             en;
  logic             abort;
  logic [WIDTH-1:0] cnt;
  logic             busy;
  logic             done;
  logic [1:0]       dbg_state;

  modport master (
    output ld_valid, ld_data, en, abort,
    input  ld_ready, cnt, busy, done, dbg_state
  );

  modport slave (
    input  ld_valid, ld_data, en, abort,
    output ld_ready, cnt, busy, done, dbg_state
  );
endinterface

// File: rtl/au_down_counter.sv
// Loadable, enable-gated down-counter/timer built around the AU_dec prefix decrementer.
// Optional periodic mode: define AU_DOWN_COUNTER_RELOAD_EN to reload on terminal count.
module AU_dec #(
  parameter int WIDTH = 8,
  parameter int ARCH  = 0
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);
  // z[i] is high when a[i:0] is all zero; bit i of a-1 flips when every lower bit is zero.
  logic [WIDTH-1:0] z;

  always_comb begin
    z = ~a;
    if (ARCH == 1) begin
      // Kogge-Stone: descending index keeps each level reading the previous level.
      for (int d = 1; d < WIDTH; d = d * 2) begin
        for (int i = WIDTH - 1; i >= d; i--) begin
          z[i] = z[i] & z[i-d];
        end
      end
    end else if (ARCH == 2) begin
      // Sklansky: odd blocks take the last prefix of the block just below them.
      for (int d = 1; d < WIDTH; d = d * 2) begin
        for (int i = 0; i < WIDTH; i++) begin
          if (((i / d) % 2) == 1) begin
            z[i] = z[i] & z[(i/d)*d-1];
          end
        end
      end
    end else begin
      for (int i = 1; i < WIDTH; i++) begin
        z[i] = z[i] & z[i-1];
      end
    end
  end

  assign y = a ^ ((z << 1) | WIDTH'(1));
endmodule

module au_down_counter #(
  parameter int WIDTH = 8,
  parameter int ARCH  = 0
) (
  input logic              clk,
  input logic              rst,
  au_down_counter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d, cnt_dec;
  logic             done_q, done_d;
  logic             load;

  AU_dec #(.WIDTH(WIDTH), .ARCH(ARCH)) u_dec (
    .a (cnt_q),
    .y (cnt_dec)
  );

  assign bus.ld_ready  = (state_q != RUN) & ~bus.abort;
  assign load          = bus.ld_valid & bus.ld_ready;
  assign bus.cnt       = cnt_q;
  assign bus.busy      = (state_q == RUN);
  assign bus.done      = done_q;
  assign bus.dbg_state = state_q;

`ifdef AU_DOWN_COUNTER_RELOAD_EN
  logic [WIDTH-1:0] reload_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reload_q <= '0;
    end else if (load) begin
      reload_q <= bus.ld_data;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (bus.abort) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (load) begin
            cnt_d = bus.ld_data;
            if (bus.ld_data == '0) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              state_d = RUN;
            end
          end
        end
        RUN: begin
          if (bus.en) begin
            // cnt is never 0 in RUN, so the decrementer never wraps.
            if (cnt_q == WIDTH'(1)) begin
              done_d = 1'b1;
`ifdef AU_DOWN_COUNTER_RELOAD_EN
              cnt_d  = reload_q;
`else
              cnt_d   = '0;
              state_d = DONE;
`endif
            end else begin
              cnt_d = cnt_dec;
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_au_down_counter.sv
// Bench for au_down_counter: three 8-bit builds (ARCH 0/1/2) and a 1-bit build share
// the same directed stimulus and are checked every cycle against a behavioural model.
module tb_au_down_counter;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmp_on = 1'b0;
  logic       ld_valid = 1'b0;
  logic       en = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] ld_data = 8'd0;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  au_down_counter_if #(.WIDTH(8)) if0 ();
  au_down_counter_if #(.WIDTH(8)) if1 ();
  au_down_counter_if #(.WIDTH(8)) if2 ();
  au_down_counter_if #(.WIDTH(1)) if3 ();

  assign if0.ld_valid = ld_valid;
  assign if0.ld_data  = ld_data;
  assign if0.en       = en;
  assign if0.abort    = abort;
  assign if1.ld_valid = ld_valid;
  assign if1.ld_data  = ld_data;
  assign if1.en       = en;
  assign if1.abort    = abort;
  assign if2.ld_valid = ld_valid;
  assign if2.ld_data  = ld_data;
  assign if2.en       = en;
  assign if2.abort    = abort;
  assign if3.ld_valid = ld_valid;
  assign if3.ld_data  = ld_data[0];
  assign if3.en       = en;
  assign if3.abort    = abort;

  au_down_counter #(.WIDTH(8), .ARCH(0)) u_a0 (.clk(clk), .rst(rst), .bus(if0));
  au_down_counter #(.WIDTH(8), .ARCH(1)) u_a1 (.clk(clk), .rst(rst), .bus(if1));
  au_down_counter #(.WIDTH(8), .ARCH(2)) u_a2 (.clk(clk), .rst(rst), .bus(if2));
  au_down_counter #(.WIDTH(1), .ARCH(1)) u_w1 (.clk(clk), .rst(rst), .bus(if3));

  // Model phase: 0 = no run loaded, 1 = counting, 2 = terminal count reached.
  typedef struct {
    int st;
    int cnt;
    int done;
    int rel;
  } mdl_t;

  localparam mdl_t M_RST = '{st: 0, cnt: 0, done: 0, rel: 0};

  mdl_t m8 = M_RST;
  mdl_t m1 = M_RST;

  function automatic mdl_t m_next(mdl_t s, int mask);
    mdl_t n;
    int   d;
    n      = s;
    n.done = 0;
    if (abort) begin
      n.st  = 0;
      n.cnt = 0;
    end else if (s.st != 1) begin
      if (ld_valid) begin
        d     = int'(ld_data) & mask;
        n.rel = d;
        n.cnt = d;
        if (d == 0) begin
          n.st   = 2;
          n.done = 1;
        end else begin
          n.st = 1;
        end
      end
    end else if (en) begin
      if (s.cnt == 1) begin
        n.done = 1;
`ifdef AU_DOWN_COUNTER_RELOAD_EN
        n.cnt = s.rel;
`else
        n.cnt = 0;
        n.st  = 2;
`endif
      end else begin
        n.cnt = s.cnt - 1;
      end
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m8 <= M_RST;
      m1 <= M_RST;
    end else begin
      m8 <= m_next(m8, 255);
      m1 <= m_next(m1, 1);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic chk_dut(input string tag, input int c, input int b, input int d,
                         input int r, input mdl_t m);
    chk({tag, ".cnt"}, c, m.cnt);
    chk({tag, ".busy"}, b, (m.st == 1) ? 1 : 0);
    chk({tag, ".done"}, d, m.done);
    chk({tag, ".ld_ready"}, r, ((m.st != 1) && !abort) ? 1 : 0);
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      chk_dut("arch0", int'(if0.cnt), int'(if0.busy), int'(if0.done), int'(if0.ld_ready), m8);
      chk_dut("arch1", int'(if1.cnt), int'(if1.busy), int'(if1.done), int'(if1.ld_ready), m8);
      chk_dut("arch2", int'(if2.cnt), int'(if2.busy), int'(if2.done), int'(if2.ld_ready), m8);
      chk_dut("w1", int'(if3.cnt), int'(if3.busy), int'(if3.done), int'(if3.ld_ready), m1);
    end
  end

  task automatic cycle(input logic v, input logic [7:0] d, input logic e, input logic a);
    ld_valid = v;
    ld_data  = d;
    en       = e;
    abort    = a;
    @(posedge clk);
    #2;
  endtask

  initial begin
    #1 rst = 1'b1;
    #1 cmp_on = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    cycle(1'b0, 8'd0, 1'b0, 1'b0);
    chk("rst_cnt", int'(if0.cnt), 0);
    chk("rst_busy", int'(if0.busy), 0);
    chk("rst_done", int'(if0.done), 0);
    chk("rst_ready", int'(if0.ld_ready), 1);

    // Load 5 with en held high.
    cycle(1'b1, 8'd5, 1'b1, 1'b0);
    chk("ld5_cnt", int'(if0.cnt), 5);
    chk("ld5_busy", int'(if0.busy), 1);
    chk("ld5_ready", int'(if0.ld_ready), 0);
    for (int i = 4; i >= 1; i--) begin
      cycle(1'b0, 8'd0, 1'b1, 1'b0);
      chk("ld5_dec", int'(if0.cnt), i);
    end
    cycle(1'b0, 8'd0, 1'b1, 1'b0);
    repeat (2) cycle(1'b0, 8'd0, 1'b0, 1'b0);
    cycle(1'b0, 8'd0, 1'b0, 1'b1);

    // Load 3, en pattern 1,0,0,1,1 with a rejected load attempt during RUN.
    cycle(1'b1, 8'd3, 1'b0, 1'b0);
    cycle(1'b0, 8'd0, 1'b1, 1'b0);
    cycle(1'b1, 8'd9, 1'b0, 1'b0);
    chk("run_ld_ignored", int'(if0.cnt), 2);
    cycle(1'b0, 8'd0, 1'b0, 1'b0);
    cycle(1'b0, 8'd0, 1'b1, 1'b0);
    cycle(1'b0, 8'd0, 1'b1, 1'b0);
    cycle(1'b0, 8'd0, 1'b0, 1'b0);
    cycle(1'b0, 8'd0, 1'b0, 1'b1);

    // Load 0 goes straight to DONE; reload 255 while done is high.
    cycle(1'b1, 8'd0, 1'b0, 1'b0);
    chk("ld0_cnt", int'(if0.cnt), 0);
    chk("ld0_done", int'(if0.done), 1);
    chk("ld0_busy", int'(if0.busy), 0);
    cycle(1'b1, 8'd255, 1'b1, 1'b0);
    chk("ldff_cnt", int'(if0.cnt), 255);
    chk("ldff_busy", int'(if0.busy), 1);
    repeat (260) cycle(1'b0, 8'd0, 1'b1, 1'b0);
    cycle(1'b0, 8'd0, 1'b0, 1'b1);

    // Abort beats a concurrent load and en.
    cycle(1'b1, 8'd10, 1'b1, 1'b0);
    repeat (4) cycle(1'b0, 8'd0, 1'b1, 1'b0);
    chk("ld10_cnt", int'(if0.cnt), 6);
    cycle(1'b1, 8'd7, 1'b1, 1'b1);
    chk("abort_cnt", int'(if0.cnt), 0);
    chk("abort_busy", int'(if0.busy), 0);
    chk("abort_done", int'(if0.done), 0);
    cycle(1'b0, 8'd0, 1'b0, 1'b0);
    chk("abort_no_done", int'(if0.done), 0);

    // Load 3 with en high for 9 cycles (periodic when reload is built in).
    cycle(1'b1, 8'd3, 1'b1, 1'b0);
    repeat (9) cycle(1'b0, 8'd0, 1'b1, 1'b0);
    repeat (3) cycle(1'b1, 8'd2, 1'b0, 1'b0);
    cycle(1'b0, 8'd0, 1'b0, 1'b1);

    // Hold in RUN while en is low.
    cycle(1'b1, 8'd4, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, 8'd0, 1'b0, 1'b0);
    chk("hold_cnt", int'(if0.cnt), 4);
    repeat (2) cycle(1'b0, 8'd0, 1'b1, 1'b0);
    cycle(1'b0, 8'd0, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a run.
    cycle(1'b1, 8'd6, 1'b1, 1'b0);
    repeat (2) cycle(1'b0, 8'd0, 1'b1, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_cnt", int'(if0.cnt), 0);
    chk("mid_rst_busy", int'(if0.busy), 0);
    chk("mid_rst_done", int'(if0.done), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) cycle(1'b0, 8'd0, 1'b1, 1'b0);
    chk("post_rst_done", int'(if0.done), 0);

    cmp_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
